// File: rtl/bvb_sched.sv
// Banked vector buffer: sweeps RAM banks, steers requested values into per-lane output FIFOs.
// Address to pop 1 cycle, pop to vec 1 cycle; a full lane FIFO leaves its id in the input FIFO.

module bvb_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr  = wr_vld & ~full;
  assign do_rd  = rd_rdy & ~empty;
  assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

module bvb_sched #(
  parameter int CHANNELS       = 4,
  parameter int COL_ID_BITS    = 10,
  parameter int RAM_SPLIT_BITS = 3,
  parameter int VAL_BITS       = 8,
  parameter int RAM_ADDR_BITS  = 10,
  parameter int FIFO_DEPTH     = 4,
  parameter int SKIP_IDLE      = 1,
  parameter int BASE_RESET     = 64,
  localparam int LOCAL_BITS    = COL_ID_BITS - RAM_SPLIT_BITS,
  localparam int RAM_WIDTH     = VAL_BITS << LOCAL_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RAM_ADDR_BITS-1:0]     base_addr,
  input  logic                         base_load,
  input  logic [CHANNELS*COL_ID_BITS-1:0] id,
  input  logic [CHANNELS-1:0]          id_fifo_empty,
  output logic [CHANNELS-1:0]          id_fifo_read,
  output logic [RAM_ADDR_BITS-1:0]     ram_addr,
  input  logic [RAM_WIDTH-1:0]         ram_data,
  output logic [CHANNELS*VAL_BITS-1:0] vec,
  output logic [CHANNELS-1:0]          vec_fifo_empty,
  input  logic [CHANNELS-1:0]          vec_fifo_read,
  output logic                         sweep_wrap
);
  localparam int BANKS = 1 << RAM_SPLIT_BITS;
  typedef logic [RAM_SPLIT_BITS-1:0] bank_t;

  bank_t                    bank, bank_d, bank_nxt, cand;
  logic                     valid_d;
  logic [RAM_ADDR_BITS-1:0] base;
  logic [CHANNELS-1:0]      hit, full;
  logic [BANKS-1:0]         req;
  logic [BANKS-1:0]         req_lane [CHANNELS];

  assign ram_addr     = base + RAM_ADDR_BITS'(bank);
  assign id_fifo_read = hit;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [COL_ID_BITS-1:0] id_c;
    logic [LOCAL_BITS-1:0]  local_c;
    logic [VAL_BITS-1:0]    val_c;
    bank_t                  bank_c;

    assign id_c        = id[c*COL_ID_BITS +: COL_ID_BITS];
    assign bank_c      = id_c[COL_ID_BITS-1 -: RAM_SPLIT_BITS];
    assign local_c     = id_c[LOCAL_BITS-1:0];
    assign val_c       = ram_data[local_c*VAL_BITS +: VAL_BITS];
    // Registered full flag: a same-cycle output pop does not open a slot.
    assign hit[c]      = valid_d & ~id_fifo_empty[c] & (bank_c == bank_d) & ~full[c];
    assign req_lane[c] = id_fifo_empty[c] ? '0 : (BANKS'(1) << bank_c);

    bvb_sched_fifo #(
      .WIDTH (VAL_BITS),
      .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (hit[c]),
      .wr_dat (val_c),
      .rd_rdy (vec_fifo_read[c]),
      .rd_dat (vec[c*VAL_BITS +: VAL_BITS]),
      .empty  (vec_fifo_empty[c]),
      .full   (full[c])
    );
  end

  // Skip mode scans bank+BANKS down to bank+1 so the nearest requested bank wins.
  always_comb begin
    req      = '0;
    cand     = bank;
    bank_nxt = bank;
    for (int c = 0; c < CHANNELS; c++) req = req | req_lane[c];
    if (SKIP_IDLE == 0) begin
      bank_nxt = bank + 1'b1;
    end else begin
      for (int k = BANKS; k >= 1; k--) begin
        cand = bank + bank_t'(k);
        if (req[cand]) bank_nxt = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank       <= '0;
      bank_d     <= '0;
      valid_d    <= 1'b0;
      base       <= RAM_ADDR_BITS'(BASE_RESET);
      sweep_wrap <= 1'b0;
    end else begin
      bank_d <= bank;
      if (base_load) begin
        base       <= base_addr;
        bank       <= '0;
        valid_d    <= 1'b0;
        sweep_wrap <= 1'b0;
      end else begin
        bank       <= bank_nxt;
        valid_d    <= 1'b1;
        sweep_wrap <= (bank_nxt < bank);
      end
    end
  end
endmodule

// File: doc/bvb_sched.md
# bvb_sched

Parametrised banked vector buffer with a request-driven bank scheduler. Each of `CHANNELS` sparse-matrix lanes presents a column id from its input FIFO. The block sweeps a banked vector RAM: one RAM word per bank, holding `2^LOCAL_BITS` packed values. It pops each id whose bank is currently on the RAM output and pushes the selected value into that lane's internal output FIFO. It sits between the column-id FIFOs and the multiply-accumulate lanes, and drives an external synchronous vector RAM.

## Interface
- `CHANNELS`, 4: number of lanes.
- `COL_ID_BITS`, 10: column id width.
- `RAM_SPLIT_BITS`, 3: id MSBs selecting the bank; there are `2^RAM_SPLIT_BITS` banks.
- `VAL_BITS`, 8: vector value width.
- `RAM_ADDR_BITS`, 10: external RAM address width.
- `FIFO_DEPTH`, 4: per-lane output FIFO depth; must be a power of 2 and at least 2.
- `SKIP_IDLE`, 1: 0 = fixed round-robin sweep; 1 = jump to the next requested bank.
- `BASE_RESET`, 64: reset value of the image base address.
- Derived: `LOCAL_BITS = COL_ID_BITS-RAM_SPLIT_BITS`; `RAM_WIDTH = VAL_BITS<<LOCAL_BITS`.
- `clk` in 1: single clock, all state on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `base_addr` in `RAM_ADDR_BITS`: new image base.
- `base_load` in 1: loads `base_addr` and restarts the sweep.
- `id` in `CHANNELS*COL_ID_BITS`: lane c's head id is in slice `[c*COL_ID_BITS +: COL_ID_BITS]`; the input FIFOs are first-word-fall-through.
- `id_fifo_empty` in `CHANNELS`: per-lane input empty flag.
- `id_fifo_read` out `CHANNELS`: per-lane pop strobe.
- `ram_addr` out `RAM_ADDR_BITS`: RAM read address; the RAM has 1-cycle read latency.
- `ram_data` in `RAM_WIDTH`: RAM read data.
- `vec` out `CHANNELS*VAL_BITS`: head of each output FIFO; 0 when that FIFO is empty.
- `vec_fifo_empty` out `CHANNELS`: per-lane output empty flag.
- `vec_fifo_read` in `CHANNELS`: per-lane output pop.
- `sweep_wrap` out 1: one-cycle pulse when the bank counter wraps from the last bank to bank 0.

## Operation
- **Stage 0 (issue).**
  - Register `bank` drives `ram_addr = base + bank`, truncated mod `2^RAM_ADDR_BITS`.
  - Each cycle, `bank_d <= bank` and `valid_d <= 1`.
- **Stage 1 (hit).** Hit for lane c when all of the following hold:
  - `valid_d` is 1;
  - `~id_fifo_empty[c]`;
  - `id_c[COL_ID_BITS-1 -: RAM_SPLIT_BITS] == bank_d`;
  - output FIFO count < `FIFO_DEPTH`. A same-cycle `vec_fifo_read` does not free space.
- **On a hit:**
  - `id_fifo_read[c]` is combinational and equals hit[c]; it is asserted in that same cycle.
  - The FIFO writes `ram_data[local_c*VAL_BITS +: VAL_BITS]`, where `local_c` is the `LOCAL_BITS` LSBs of `id_c`.
- **Bank advance, `SKIP_IDLE=0`:** `bank <= bank+1` mod `2^RAM_SPLIT_BITS` every cycle.
- **Bank advance, `SKIP_IDLE=1`:**
  - Request mask = banks of all lanes with `~id_fifo_empty`, evaluated on raw head ids.
  - `bank <=` first requested bank in circular order `bank+1, …, bank`.
  - If the mask is empty, hold `bank`.
  - A stale head (popped in the same cycle) can cause one visit with no hit; this is permitted.
- `sweep_wrap` pulses on the cycle `bank` is registered 0 coming from `2^RAM_SPLIT_BITS-1`. In skip mode it pulses on any transition to a numerically lower bank.
- **`base_load`:** `base <= base_addr`, `bank <= 0`, `valid_d <= 0`. The in-flight read is discarded, so no hits occur in the next cycle. `base_load` has priority over bank advance.
- **Output FIFOs:**
  - Read of an empty FIFO is ignored.
  - A write is never issued to a full FIFO.
  - Simultaneous read and write on a non-empty FIFO keeps the count constant.
  - Write and read on an empty FIFO: the new word appears next cycle; the read is ignored.

## Timing
- **Reset values:**
  - `bank=0`, `bank_d=0`, `valid_d=0`, `base=BASE_RESET`.
  - `ram_addr=BASE_RESET`.
  - `id_fifo_read=0`, `vec=0`, `vec_fifo_empty` all 1, `sweep_wrap=0`, all FIFOs empty.
  - Reset mid-operation flushes the FIFOs; ids not yet popped stay in the input FIFOs.
- **Hit timing:** address issued at cycle t → hit evaluated and pop at t+1 → `vec_fifo_empty[c]` falls and `vec` is valid at t+2.
- **Worst-case id-to-pop latency:**
  - `SKIP_IDLE=0`: `2^RAM_SPLIT_BITS+1` cycles.
  - `SKIP_IDLE=1`: at most `CHANNELS+1` cycles while that lane's FIFO has space.
- **Throughput:** per lane, one pop per cycle while consecutive ids map to the bank currently in stage 1.

## Test plan
Bench parameters: `CHANNELS=2`, `COL_ID_BITS=5`, `RAM_SPLIT_BITS=2`, `VAL_BITS=8`, `FIFO_DEPTH=4`, `BASE_RESET=64`. RAM model: at address a, byte k = (a-64)*8+k. With this model, value == id.

1. **Reset.** Assert `rst` asynchronously mid-cycle → all outputs take reset values immediately; `ram_addr=64`.
2. **Round robin.** `SKIP_IDLE=0`; lane 0 ids 0x0D, 0x02, 0x1F → `vec` pops in order 13, 2, 31. Each pop occurs exactly 1 cycle after `ram_addr` equals 64+bank. `sweep_wrap` pulses every 4 cycles.
3. **Skip mode.** `SKIP_IDLE=1`; lane 0 = 0x18, lane 1 = 0x19, starting from bank 0 → banks 1 and 2 are never visited. Both lanes pop in the same cycle, 2 cycles after the ids appear. `vec` = 24 and 25.
4. **Full FIFO backpressure.** Lane 1 `vec_fifo_read=0`; push 6 ids from bank 0 → exactly 4 pops and the count stays at 4. Assert `vec_fifo_read` for 1 cycle → a 5th pop on the next visit to bank 0.
5. **Base reload.** Pulse `base_load` with `base_addr=100` while a lane-0 hit is in flight → no pop in the following cycle. The next `ram_addr` is 100. A later hit returns RAM contents at 100+bank.
6. **Simultaneous push and pop on a full FIFO.** Lane 0 FIFO full, `vec_fifo_read` held high, a matching id present → no push that cycle; the count drops to 3. The push occurs on the next visit to that bank.
